// File: rtl/scan_display_driver.sv
// Time-multiplexed common-anode seven-segment scanner with guard interval, PWM dimming and frame strobe.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is never blanked).
module scan_display_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 262144,
  parameter int GUARD_CYCLES = 16,
  parameter int PWM_BITS     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dots,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]      cnt;
  logic [SEL_W-1:0]      sel;
  logic [3:0]            cap_val;
  logic                  cap_dot;
  logic                  cap_en;
  logic                  cap_blank;

  logic                  slot_end;
  logic                  last_digit;
  logic                  in_guard;
  logic [PWM_BITS-1:0]   cnt_lo;
  logic                  pwm_on;
  logic [3:0]            cur_val;
  logic                  blank_now;
  logic [NUM_DIGITS-1:0] on_mask;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign slot_end   = (cnt == CNT_W'(DWELL_CYCLES - 1));
  assign last_digit = (sel == SEL_W'(NUM_DIGITS - 1));
  assign in_guard   = (cnt < CNT_W'(GUARD_CYCLES));
  assign cnt_lo     = PWM_BITS'(cnt);
  assign pwm_on     = (&brightness) || (cnt_lo < brightness);
  assign cur_val    = digits[{sel, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  // Blank when this digit and every digit to its left read zero at capture time.
  always_comb begin
    blank_now = (sel != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((SEL_W'(i) >= sel) && (digits[4*i +: 4] != 4'h0)) blank_now = 1'b0;
    end
  end
`else
  assign blank_now = 1'b0;
`endif

  always_comb begin
    on_mask = '1;
    if (cap_en && pwm_on) on_mask[sel] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      sel        <= '0;
      cap_val    <= 4'h0;
      cap_dot    <= 1'b0;
      cap_en     <= 1'b0;
      cap_blank  <= 1'b0;
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        sel <= last_digit ? '0 : sel + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Slot contents are frozen at the first cycle so mid-slot input changes are invisible.
      if (cnt == '0) begin
        cap_val   <= cur_val;
        cap_dot   <= dots[sel];
        cap_en    <= digit_en[sel];
        cap_blank <= blank_now;
      end

      frame_tick <= slot_end && last_digit;

      if (in_guard) begin
        an  <= '1;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end else begin
        an  <= on_mask;
        seg <= cap_blank ? 7'h7F : hex_to_seg(cap_val);
        dp  <= ~cap_dot;
      end
    end
  end

endmodule
